i2c_slave: RTL



---
 rtl/i2c_slave.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target endpoint: conditions SCL/SDA, tracks START/STOP, matches a fixed
// 7-bit address, streams written bytes out and fetches read bytes on request.
module i2c_slave #(
    parameter logic [6:0] ADDRESS       = 7'h68,
    parameter int         FILTER_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    output logic       scl_t,
    output logic       scl_o,
    input  logic       sda_i,
    output logic       sda_t,
    output logic       sda_o,
    output logic       busy,
    output logic       rw,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    output logic       wr_first,
    input  logic       wr_ack,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       rd_nack
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WRITE_ACK = 3'd4;
    localparam logic [2:0] S_READ      = 3'd5;
    localparam logic [2:0] S_READ_ACK  = 3'd6;
    localparam logic [2:0] S_IGNORE    = 3'd7;

    logic [1:0] w_pin;
    logic [1:0] w_filt;
    assign w_pin = {sda_i, scl_i};

    // Channel 0 is SCL, channel 1 is SDA: synchronize, then require a stable level.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic          r_s1;
            logic          r_s2;
            logic          r_f;
            logic [CW-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_f   <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_pin[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_f) begin
                        r_cnt <= '0;
                    end else if (r_cnt == FILT_LAST) begin
                        r_f   <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
            assign w_filt[gi] = r_f;
        end
    endgenerate

    logic       w_scl_f, w_sda_f;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    logic       r_scl_d, r_sda_d;
    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_sda_t, r_busy, r_rw;
    logic       r_wr_valid, r_wr_first, r_first_pend, r_wr_ack;
    logic [7:0] r_wr_data;
    logic       r_rd_req, r_rd_nack;
    logic       r_ack_phase;

    assign w_scl_f    = w_filt[0];
    assign w_sda_f    = w_filt[1];
    assign w_scl_rise = w_scl_f & ~r_scl_d;
    assign w_scl_fall = ~w_scl_f & r_scl_d;
    assign w_start    = w_scl_f & r_sda_d & ~w_sda_f;
    assign w_stop     = w_scl_f & ~r_sda_d & w_sda_f;
    assign w_byte     = {r_shift[6:0], w_sda_f};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_d      <= 1'b1;
            r_sda_d      <= 1'b1;
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_sda_t      <= 1'b1;
            r_busy       <= 1'b0;
            r_rw         <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_data    <= '0;
            r_wr_first   <= 1'b0;
            r_first_pend <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_rd_req     <= 1'b0;
            r_rd_nack    <= 1'b0;
            r_ack_phase  <= 1'b0;
        end else begin
            r_scl_d    <= w_scl_f;
            r_sda_d    <= w_sda_f;
            r_wr_valid <= 1'b0;
            r_rd_req   <= 1'b0;
            r_rd_nack  <= 1'b0;
            // The user answers wr_ack in the wr_valid cycle; hold it for the ACK slot.
            if (r_wr_valid) begin
                r_wr_ack <= wr_ack;
            end
            if (w_start) begin
                r_state     <= S_ADDR;
                r_bit_cnt   <= '0;
                r_sda_t     <= 1'b1;
                r_busy      <= 1'b0;
                r_ack_phase <= 1'b0;
            end else if (w_stop) begin
                r_state     <= S_IDLE;
                r_sda_t     <= 1'b1;
                r_busy      <= 1'b0;
                r_ack_phase <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_byte[7:1] == ADDRESS) begin
                                    r_rw        <= w_byte[0];
                                    r_rd_req    <= w_byte[0];
                                    r_ack_phase <= 1'b0;
                                    r_state     <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_sda_t     <= 1'b0;
                                r_ack_phase <= 1'b1;
                            end else begin
                                r_ack_phase <= 1'b0;
                                r_busy      <= 1'b1;
                                r_bit_cnt   <= '0;
                                if (r_rw) begin
                                    r_shift <= rd_data;
                                    r_sda_t <= rd_data[7];
                                    r_state <= S_READ;
                                end else begin
                                    r_sda_t      <= 1'b1;
                                    r_first_pend <= 1'b1;
                                    r_state      <= S_WRITE;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_wr_valid   <= 1'b1;
                                r_wr_data    <= w_byte;
                                r_wr_first   <= r_first_pend;
                                r_first_pend <= 1'b0;
                                r_ack_phase  <= 1'b0;
                                r_state      <= S_WRITE_ACK;
                            end
                        end
                    end
                    S_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_sda_t     <= ~r_wr_ack;
                                r_ack_phase <= 1'b1;
                            end else begin
                                r_sda_t     <= 1'b1;
                                r_ack_phase <= 1'b0;
                                r_state     <= S_WRITE;
                            end
                        end
                    end
                    S_READ: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_sda_t     <= 1'b1;
                                r_bit_cnt   <= '0;
                                r_ack_phase <= 1'b0;
                                r_state     <= S_READ_ACK;
                            end else begin
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_sda_t   <= r_shift[6];
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_READ_ACK: begin
                        // r_ack_phase marks "master ACKed, next byte loads on the coming fall".
                        if (w_scl_rise && !r_ack_phase) begin
                            if (!w_sda_f) begin
                                r_rd_req    <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else begin
                                r_rd_nack <= 1'b1;
                                r_state   <= S_IGNORE;
                            end
                        end else if (w_scl_fall && r_ack_phase) begin
                            r_shift     <= rd_data;
                            r_sda_t     <= rd_data[7];
                            r_bit_cnt   <= '0;
                            r_ack_phase <= 1'b0;
                            r_state     <= S_READ;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign scl_t    = 1'b1;
    assign scl_o    = 1'b0;
    assign sda_o    = 1'b0;
    assign sda_t    = r_sda_t;
    assign busy     = r_busy;
    assign rw       = r_rw;
    assign wr_valid = r_wr_valid;
    assign wr_data  = r_wr_data;
    assign wr_first = r_wr_first;
    assign rd_req   = r_rd_req;
    assign rd_nack  = r_rd_nack;

endmodule
